// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor. One full-adder cell (two half-adder stages plus
// an OR) and a carry flip-flop process one operand bit per clock, LSB first.
// A start/done handshake lets a controller issue operations and collect
// registered results.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    // Counter is one bit wider than needed to index WIDTH-1 so WIDTH=32 cannot wrap.
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic a0, b0;
    logic ha1_s, ha1_c;
    logic ha2_s, ha2_c;
    logic fa_sum, fa_carry;
    logic last_bit;

    // Full adder built from two half-adder stages; the carry flop feeds stage two.
    always_comb begin
        a0       = opa_q[0];
        b0       = opb_q[0];
        ha1_s    = a0 ^ b0;
        ha1_c    = a0 & b0;
        ha2_s    = ha1_s ^ carry_q;
        ha2_c    = ha1_s & carry_q;
        fa_sum   = ha2_s;
        fa_carry = ha1_c | ha2_c;
        last_bit = (cnt_q == LAST_BIT);
    end

    // Next-state: accept in IDLE/DONE, shift one bit per cycle in RUN.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    opa_d   = a;
                    // Subtraction is A + ~B + 1: invert B here, seed the carry with 1.
                    opb_d   = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = fa_sum;
                opa_d            = opa_q >> 1;
                opb_d            = opb_q >> 1;
                carry_d          = fa_carry;
                cnt_d            = cnt_q + CNT_ONE;
                if (last_bit) begin
                    sum_d   = res_d;
                    cout_d  = fa_carry;
                    // carry_q is the carry into the MSB while the MSB is processed.
                    ovf_d   = carry_q ^ fa_carry;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

`ifndef SYNTHESIS
    // Handshake sanity: never busy and done together, no unused state encoding.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(busy_q && done_q));
            assert (state_q != 2'd3);
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (WIDTH 8, 1, 32) share a
// clock and reset. The driver pushes expected results; a negedge monitor pops
// and compares on every DONE pulse and checks that results hold otherwise.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        st8, sb8, busy8, done8, co8, ov8;
    logic [7:0]  a8, b8, s8;
    logic        st1, sb1, busy1, done1, co1, ov1;
    logic [0:0]  a1, b1, s1;
    logic        st32, sb32, busy32, done32, co32, ov32;
    logic [31:0] a32, b32, s32;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .sub(sb8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(s8), .carry_out(co8), .overflow(ov8)
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(st1), .sub(sb1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(s1), .carry_out(co1), .overflow(ov1)
    );
    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(st32), .sub(sb32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .sum(s32), .carry_out(co32), .overflow(ov32)
    );

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        co;
        logic        ov;
        int          edge_n;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          passed = 0;
    int          ecount = 0;
    bit          mon_en = 0;
    logic        busy_v[3], done_v[3], co_v[3], ov_v[3];
    logic [31:0] sum_v[3];
    logic [31:0] hold_sum[3];
    logic        hold_co[3], hold_ov[3];
    int          busy_run[3];

    always @(posedge clk) ecount <= ecount + 1;

    always_comb begin
        busy_v[0] = busy8;  done_v[0] = done8;  co_v[0] = co8;  ov_v[0] = ov8;
        sum_v[0]  = {24'd0, s8};
        busy_v[1] = busy1;  done_v[1] = done1;  co_v[1] = co1;  ov_v[1] = ov1;
        sum_v[1]  = {31'd0, s1};
        busy_v[2] = busy32; done_v[2] = done32; co_v[2] = co32; ov_v[2] = ov32;
        sum_v[2]  = s32;
    end

    function automatic int wof(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 1 : 32);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference arithmetic: A + (SUB ? ~B : B) + SUB, modulo 2^w.
    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic sv, output logic [31:0] s, output logic co,
                                  output logic ov);
        longint unsigned mask, am, bm, full;
        mask = (64'd1 << w) - 64'd1;
        am   = {32'd0, av} & mask;
        bm   = {32'd0, (sv ? ~bv : bv)} & mask;
        full = am + bm + (sv ? 64'd1 : 64'd0);
        s    = full[31:0] & mask[31:0];
        co   = full[w];
        ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (done_v[k]) begin
                    chk($sformatf("busy_with_done_w%0d", wof(k)), {31'd0, busy_v[k]}, 32'd0);
                    chk($sformatf("busy_len_w%0d", wof(k)), busy_run[k], wof(k));
                    if (q.size() == 0 || q[0].id != k) begin
                        total++;
                        $display("FAIL unexpected_done_w%0d: got done=1 expected no pending op",
                                 wof(k));
                    end else begin
                        mon_e = q.pop_front();
                        chk($sformatf("sum_w%0d", wof(k)), sum_v[k], mon_e.sum);
                        chk($sformatf("carry_w%0d", wof(k)), {31'd0, co_v[k]}, {31'd0, mon_e.co});
                        chk($sformatf("ovf_w%0d", wof(k)), {31'd0, ov_v[k]}, {31'd0, mon_e.ov});
                        chk($sformatf("latency_w%0d", wof(k)), ecount - mon_e.edge_n, wof(k));
                        hold_sum[k] = mon_e.sum;
                        hold_co[k]  = mon_e.co;
                        hold_ov[k]  = mon_e.ov;
                    end
                end else begin
                    chk($sformatf("sum_hold_w%0d", wof(k)), sum_v[k], hold_sum[k]);
                    chk($sformatf("flags_hold_w%0d", wof(k)), {30'd0, co_v[k], ov_v[k]},
                        {30'd0, hold_co[k], hold_ov[k]});
                end
                busy_run[k] = busy_v[k] ? busy_run[k] + 1 : 0;
            end
        end
    end

    task automatic zero_holds();
        for (int k = 0; k < 3; k++) begin
            hold_sum[k] = '0;
            hold_co[k]  = 1'b0;
            hold_ov[k]  = 1'b0;
        end
    endtask

    task automatic issue(input int k, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic [31:0] es, input logic eco,
                         input logic eov, input bit keep);
        case (k)
            0: begin a8 = av[7:0]; b8 = bv[7:0]; sb8 = sv; st8 = 1'b1; end
            1: begin a1 = av[0:0]; b1 = bv[0:0]; sb1 = sv; st1 = 1'b1; end
            default: begin a32 = av; b32 = bv; sb32 = sv; st32 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        q.push_back('{k, es, eco, eov, ecount});
        if (!keep) begin
            st8 = 1'b0; st1 = 1'b0; st32 = 1'b0;
        end
    endtask

    task automatic issue_model(input int k, input logic [31:0] av, input logic [31:0] bv,
                               input logic sv);
        logic [31:0] es;
        logic        eco, eov;
        model(wof(k), av, bv, sv, es, eco, eov);
        issue(k, av, bv, sv, es, eco, eov, 1'b0);
    endtask

    // Operands that must be ignored while an operation is in flight.
    task automatic garbage8();
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        sb8 = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        st8 = 0; sb8 = 0; a8 = 0; b8 = 0;
        st1 = 0; sb1 = 0; a1 = 0; b1 = 0;
        st32 = 0; sb32 = 0; a32 = 0; b32 = 0;
        zero_holds();
        for (int k = 0; k < 3; k++) busy_run[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy_w%0d", wof(k)), {31'd0, busy_v[k]}, 32'd0);
            chk($sformatf("rst_done_w%0d", wof(k)), {31'd0, done_v[k]}, 32'd0);
            chk($sformatf("rst_sum_w%0d", wof(k)), sum_v[k], 32'd0);
            chk($sformatf("rst_co_w%0d", wof(k)), {31'd0, co_v[k]}, 32'd0);
            chk($sformatf("rst_ov_w%0d", wof(k)), {31'd0, ov_v[k]}, 32'd0);
        end
        reset  = 1'b0;
        mon_en = 1'b1;

        // WIDTH=8 directed vectors, expected values worked by hand.
        issue(0, 32'h3C, 32'h05, 1'b0, 32'h41, 1'b0, 1'b0, 1'b0); wait_drain();
        issue(0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0); wait_drain();
        issue(0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0); wait_drain();
        issue(0, 32'h05, 32'h07, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b0); wait_drain();
        issue(0, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, 1'b0); wait_drain();
        issue(0, 32'h33, 32'h33, 1'b1, 32'h00, 1'b1, 1'b0, 1'b0); wait_drain();

        // START held high; operands change every cycle, only accepting edges count.
        issue(0, 32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1'b0, 1'b1);
        repeat (8) garbage8();
        issue(0, 32'h90, 32'h10, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1);
        repeat (8) garbage8();
        issue(0, 32'h64, 32'h64, 1'b0, 32'hC8, 1'b0, 1'b1, 1'b1);
        repeat (8) garbage8();
        st8 = 1'b0;
        wait_drain();

        // Reset during the 4th RUN cycle discards the operation.
        issue(0, 32'h12, 32'h34, 1'b0, 32'h46, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        zero_holds();
        chk("midrst_busy", {31'd0, busy8}, 32'd0);
        chk("midrst_done", {31'd0, done8}, 32'd0);
        chk("midrst_sum", {24'd0, s8}, 32'd0);
        issue(0, 32'hAA, 32'h55, 1'b0, 32'hFF, 1'b0, 1'b0, 1'b0); wait_drain();

        // WIDTH=1: every operand/mode combination.
        for (int i = 0; i < 8; i++) begin
            issue_model(1, {31'd0, i[0]}, {31'd0, i[1]}, i[2]);
            wait_drain();
        end

        // WIDTH=32: corner values then random operands.
        issue_model(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0); wait_drain();
        issue_model(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0); wait_drain();
        issue_model(2, 32'h0000_0000, 32'h0000_0001, 1'b1); wait_drain();
        issue_model(2, 32'h8000_0000, 32'h0000_0001, 1'b1); wait_drain();
        for (int i = 0; i < 6; i++) begin
            issue_model(2, $urandom, $urandom, 1'($urandom));
            wait_drain();
        end

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor: the sequential successor to the single-bit half adder. It adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, using a single full-adder cell (two half-adder stages plus an OR) and a carry flip-flop. It trades latency for area and provides a start/done handshake so a controller or processor datapath can issue operations and collect registered results.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 1 to 32.
- CLK  input  1  rising-edge clock, the only clock.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only when the block is ready (state IDLE or DONE).
- SUB  input  1  mode, sampled with START: 0 computes A+B, 1 computes A-B.
- A  input  WIDTH  first operand, sampled with START.
- B  input  WIDTH  second operand, sampled with START.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse: results updated this cycle.
- SUM  output  WIDTH  registered result, held until the next completion.
- CARRY_OUT  output  1  carry out of the MSB; when SUB=1, 1 means no borrow (A >= B unsigned).
- OVERFLOW  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- Accept: at an edge with START=1 in IDLE or DONE:
  - latch A into the operand-A shift register;
  - latch B XOR {WIDTH{SUB}} into the operand-B shift register;
  - set carry flip-flop to SUB;
  - clear the bit counter;
  - go to RUN.
- RUN, each edge:
  - bit = a0 ^ b0 ^ c;
  - c <= (a0 & b0) | (c & (a0 ^ b0));
  - shift bit into the result shift register from the MSB side;
  - shift both operand registers right;
  - counter increments.
- On the edge processing bit WIDTH-1:
  - copy the completed result into SUM;
  - CARRY_OUT <= new carry;
  - OVERFLOW <= carry into MSB XOR new carry;
  - go to DONE.
- DONE lasts one cycle. Without START it returns to IDLE; with START it accepts immediately (back-to-back operation).
- START in RUN is ignored; no queuing, and no effect on the operation in flight.
- A, B and SUB are don't-care except at the accepting edge.
- SUM, CARRY_OUT and OVERFLOW change only at completion and at RESET.
- Arithmetic is modulo 2^WIDTH. WIDTH=1 is legal: RUN lasts one cycle.
- The counter is $clog2(WIDTH)+1 bits wide so WIDTH=32 works without wrapping.

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, SUM=0, CARRY_OUT=0, OVERFLOW=0, all internal registers 0.
- RESET has priority over everything. Asserting it mid-operation discards the operation; outputs read reset values the cycle after the edge.
- Let E0 be the accepting edge:
  - BUSY=1 from after E0 until after E_WIDTH;
  - edges E1..E_WIDTH process bits 0..WIDTH-1;
  - after E_WIDTH: BUSY=0, DONE=1, results valid;
  - after E_{WIDTH+1}: DONE=0, or BUSY=1 again if START was high at E_{WIDTH+1}.
- Latency START-to-DONE is WIDTH+1 edges. Throughput is one operation per WIDTH+1 cycles.
- BUSY and DONE are never high together. Both are registered outputs with no combinational path from inputs.

## Test plan
- WIDTH=8: A=0x3C, B=0x05, SUB=0, START pulsed one cycle.
  - Required: BUSY high for 8 cycles, then DONE for 1 cycle.
  - SUM=0x41, CARRY_OUT=0, OVERFLOW=0.
- Carry and overflow:
  - 0xFF+0x01 gives SUM=0x00, CARRY_OUT=1, OVERFLOW=0.
  - 0x7F+0x01 gives SUM=0x80, CARRY_OUT=0, OVERFLOW=1.
- Subtract:
  - 0x05-0x07 gives SUM=0xFE, CARRY_OUT=0, OVERFLOW=0.
  - 0x80-0x01 gives SUM=0x7F, CARRY_OUT=1, OVERFLOW=1.
- START held high continuously with operands changing while BUSY:
  - Only operands present at accepting edges are used.
  - Back-to-back DONE pulses exactly 9 cycles apart; SUM holds between them.
- RESET at the 4th RUN cycle:
  - Next cycle: BUSY=0, DONE=0, SUM=0.
  - A fresh START then completes correctly after 9 cycles.
- WIDTH=1 and WIDTH=32 builds, randomised operands against a reference model:
  - DONE 2 and 33 cycles after START respectively;
  - all SUM, CARRY_OUT and OVERFLOW values match the model.
